// File: rtl/src_frame_arbiter_pkg.sv
// Shared definitions for the two-source frame arbiter feeding the SSD write FIFO.
// Holds FSM encoding, source identifiers and the FIFO geometry.
package src_frame_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic SRC_TPG = 1'b0;
    localparam logic SRC_ACQ = 1'b1;

    localparam int FIFO_DEPTH = 16384;
    localparam int WRUSEDW_W  = 14;

    // One-hot read strobe for the selected source.
    function automatic logic [1:0] src_onehot(input logic src);
        return (src == SRC_ACQ) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/src_frame_arbiter_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational; the caller owns the
// "last granted" pointer and updates it only when a grant is actually taken.
module src_frame_arbiter_rr_arb2 (
    input  logic [1:0] elig,
    input  logic       last,
    output logic       gnt_vld,
    output logic       gnt_idx
);

    always_comb begin
        gnt_vld = |elig;
        gnt_idx = elig[1];
        if (elig == 2'b11) begin
            gnt_idx = ~last;
        end
    end

endmodule

// File: rtl/src_frame_arbiter.sv
// Grants whole frames from the test-pattern and acquisition sources onto the
// SSD write FIFO, round-robin, only when the FIFO can absorb a complete frame.
module src_frame_arbiter
    import src_frame_arbiter_pkg::*;
#(
    parameter int FRAME_WORDS = 512,
    parameter int FILL_LIMIT  = 7680,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             run,
    input  logic [1:0]       src_en,
    input  logic [13:0]      wrusedw,
    input  logic [1:0]       src_req,
    output logic [1:0]       src_rd,
    input  logic [15:0]      src0_data,
    input  logic [15:0]      src1_data,
    output logic [15:0]      fifo_data,
    output logic             fifo_wr,
    output logic             busy,
    output logic             cur_src,
    output logic [CNT_W-1:0] frames0,
    output logic [CNT_W-1:0] frames1
);

    localparam int                        WC_W     = $clog2(FRAME_WORDS);
    localparam logic [WC_W-1:0]           WC_LAST  = WC_W'(FRAME_WORDS - 1);
    localparam logic [WRUSEDW_W-1:0]      FILL_LIM = WRUSEDW_W'(FILL_LIMIT);

    if ((FILL_LIMIT > FIFO_DEPTH - FRAME_WORDS) || (FRAME_WORDS < 2) ||
        ((FRAME_WORDS & (FRAME_WORDS - 1)) != 0)) begin : g_param_check
        $error("src_frame_arbiter: illegal FRAME_WORDS/FILL_LIMIT combination");
    end

    state_t          state;
    state_t          state_nxt;
    logic            last;
    logic [WC_W-1:0] wc;
    logic            flush_ph;
    logic [1:0]      elig;
    logic            space_ok;
    logic            gnt_vld;
    logic            gnt_idx;
    logic            take_grant;
    logic            flush_done;
    logic            rd_d1;
    logic            src_d1;

    assign elig     = src_req & src_en & {2{run}};
    assign space_ok = (wrusedw < FILL_LIM);

    src_frame_arbiter_rr_arb2 u_rr_arb2 (
        .elig    (elig),
        .last    (last),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt  = state;
        src_rd     = 2'b00;
        take_grant = 1'b0;
        flush_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (space_ok && gnt_vld) begin
                    take_grant = 1'b1;
                    state_nxt  = ST_XFER;
                end
            end
            ST_XFER: begin
                src_rd = src_onehot(cur_src);
                if (wc == WC_LAST) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_ph) begin
                    flush_done = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!nRST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pointer starts at ACQ so the test-pattern source wins the first grant.
    always_ff @(posedge clk) begin
        if (!nRST) begin
            last     <= SRC_ACQ;
            cur_src  <= SRC_TPG;
            busy     <= 1'b0;
            wc       <= '0;
            flush_ph <= 1'b0;
            frames0  <= '0;
            frames1  <= '0;
        end else begin
            if (take_grant) begin
                cur_src  <= gnt_idx;
                last     <= gnt_idx;
                busy     <= 1'b1;
                wc       <= '0;
                flush_ph <= 1'b0;
            end
            if (state == ST_XFER) begin
                wc <= wc + WC_W'(1);
            end
            if (state == ST_FLUSH) begin
                flush_ph <= ~flush_ph;
            end
            if (flush_done) begin
                busy <= 1'b0;
                if (cur_src == SRC_ACQ) begin
                    frames1 <= frames1 + CNT_W'(1);
                end else begin
                    frames0 <= frames0 + CNT_W'(1);
                end
            end
        end
    end

    // Two-stage write path: strobe -> source word -> registered FIFO write.
    // NOTE: no storage here is memory-like; every flop is reset so an aborted frame leaves no write pending.
    always_ff @(posedge clk) begin
        if (!nRST) begin
            rd_d1     <= 1'b0;
            src_d1    <= SRC_TPG;
            fifo_wr   <= 1'b0;
            fifo_data <= '0;
        end else begin
            rd_d1   <= (state == ST_XFER);
            src_d1  <= cur_src;
            fifo_wr <= rd_d1;
            if (rd_d1) begin
                fifo_data <= (src_d1 == SRC_TPG) ? src0_data : src1_data;
            end
        end
    end

endmodule

// File: tb/tb_src_frame_arbiter.sv
// Scoreboard bench for src_frame_arbiter: source models push each emitted word,
// a monitor pops and compares on every FIFO write and logs strobe/write bursts.
module tb_src_frame_arbiter;

    localparam int FW = 512;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          nRST = 1'b0;
    logic          run = 1'b0;
    logic [1:0]    src_en = 2'b00;
    logic [1:0]    src_req = 2'b00;
    logic [13:0]   wrusedw = 14'd0;
    logic [15:0]   src0_data = 16'd0;
    logic [15:0]   src1_data = 16'd0;
    logic [1:0]    src_rd;
    logic [15:0]   fifo_data;
    logic          fifo_wr;
    logic          busy;
    logic          cur_src;
    logic [CW-1:0] frames0;
    logic [CW-1:0] frames1;

    src_frame_arbiter #(
        .FRAME_WORDS (FW),
        .FILL_LIMIT  (7680),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .nRST      (nRST),
        .run       (run),
        .src_en    (src_en),
        .wrusedw   (wrusedw),
        .src_req   (src_req),
        .src_rd    (src_rd),
        .src0_data (src0_data),
        .src1_data (src1_data),
        .fifo_data (fifo_data),
        .fifo_wr   (fifo_wr),
        .busy      (busy),
        .cur_src   (cur_src),
        .frames0   (frames0),
        .frames1   (frames1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic src;
        int   len;
        int   start;
        int   last;
    } run_t;

    run_t        bursts[$];
    run_t        rd_runs[$];
    logic [15:0] sb[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int rd_starts = 0;
    int rd_bad = 0;
    int busy_fall_cyc = -1;
    int s0_n = 0;
    int s1_n = 0;
    logic r0 = 1'b0;
    logic r1 = 1'b0;
    int   wlen = 0, wstart = 0, wlast = 0, rlen = 0, rstart = 0;
    logic wsrc = 1'b0, rsrc = 1'b0, busy_q = 1'b0;
    int   c_mark = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Source models: a strobe seen in cycle t yields the next word in cycle t+1.
    initial begin
        forever begin
            @(negedge clk);
            r0 = (src_rd[0] === 1'b1);
            r1 = (src_rd[1] === 1'b1);
            @(posedge clk);
            #1;
            if (r0) begin
                src0_data = {1'b0, 15'(s0_n)};
                sb.push_back(src0_data);
                s0_n++;
            end
            if (r1) begin
                src1_data = {1'b1, 15'(s1_n)};
                sb.push_back(src1_data);
                s1_n++;
            end
        end
    end

    // Monitor: compares every FIFO write against the scoreboard and logs bursts.
    initial begin
        forever begin
            @(negedge clk);
            if (fifo_wr === 1'b1) begin
                check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) check("fifo_data", 32'(fifo_data), 32'(sb.pop_front()));
                if (wlen == 0) begin
                    wstart = cyc;
                    wsrc   = fifo_data[15];
                end
                wlen++;
                wlast = cyc;
            end else if (wlen != 0) begin
                bursts.push_back('{wsrc, wlen, wstart, wlast});
                wlen = 0;
            end
            if (src_rd === 2'b11 || (src_rd !== 2'b00 && busy !== 1'b1)) rd_bad++;
            if (src_rd === 2'b01 || src_rd === 2'b10) begin
                if (rlen == 0) begin
                    rstart = cyc;
                    rsrc   = src_rd[1];
                    rd_starts++;
                end
                rlen++;
            end else if (rlen != 0) begin
                rd_runs.push_back('{rsrc, rlen, rstart, rstart + rlen - 1});
                rlen = 0;
            end
            if (busy_q && busy === 1'b0) busy_fall_cyc = cyc;
            busy_q = (busy === 1'b1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        run = 1'b0;
        src_en = 2'b00;
        src_req = 2'b00;
        wrusedw = 14'd0;
        tick(3);
        bursts.delete();
        rd_runs.delete();
        sb.delete();
        rd_starts = 0;
        busy_fall_cyc = -1;
        nRST = 1'b1;
    endtask

    task automatic wait_starts(input int n, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (rd_starts >= n) break;
            tick(1);
        end
        check(name, 32'(rd_starts >= n), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single source, reset values, latency and frame shape.
        do_reset();
        @(negedge clk);
        check("rst_src_rd", 32'(src_rd), 32'd0);
        check("rst_fifo_wr", 32'(fifo_wr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cur_src", 32'(cur_src), 32'd0);
        check("rst_frames0", 32'(frames0), 32'd0);
        check("rst_frames1", 32'(frames1), 32'd0);
        tick(1);
        src_en = 2'b01; src_req = 2'b01; run = 1'b1;
        wait_starts(1, 10, "t1_grant");
        src_req = 2'b00;
        tick(530);
        check("t1_rd_runs", 32'(rd_runs.size()), 32'd1);
        check("t1_bursts", 32'(bursts.size()), 32'd1);
        if (rd_runs.size() == 1 && bursts.size() == 1) begin
            check("t1_rd_len", 32'(rd_runs[0].len), FW);
            check("t1_rd_src", 32'(rd_runs[0].src), 32'd0);
            check("t1_wr_len", 32'(bursts[0].len), FW);
            check("t1_latency", 32'(bursts[0].start - rd_runs[0].start), 32'd2);
            check("t1_busy_fall", 32'(busy_fall_cyc - bursts[0].last), 32'd1);
        end
        check("t1_frames0", 32'(frames0), 32'd1);
        check("t1_frames1", 32'(frames1), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_sb_empty", 32'(sb.size()), 32'd0);

        // Round-robin with both sources requesting.
        do_reset();
        src_en = 2'b11; src_req = 2'b11; run = 1'b1;
        wait_starts(4, 4 * 520 + 50, "t2_four_grants");
        src_req = 2'b00;
        tick(530);
        check("t2_bursts", 32'(bursts.size()), 32'd4);
        if (bursts.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t2_order", 32'(bursts[i].src), 32'(i % 2));
                check("t2_len", 32'(bursts[i].len), FW);
            end
            check("t2_gap", 32'(bursts[1].start - bursts[0].last - 1), 32'd3);
        end
        check("t2_frames0", 32'(frames0), 32'd2);
        check("t2_frames1", 32'(frames1), 32'd2);
        check("t2_sb_empty", 32'(sb.size()), 32'd0);

        // Space gate at the fill limit, and a level jump mid-frame.
        do_reset();
        wrusedw = 14'd7680; src_en = 2'b11; src_req = 2'b11; run = 1'b1;
        tick(100);
        check("t3_no_grant_full", 32'(rd_starts), 32'd0);
        wrusedw = 14'd7679;
        c_mark = cyc;
        wait_starts(1, 5, "t3_grant_after_drop");
        src_req = 2'b00;
        tick(20);
        wrusedw = 14'd16000;
        tick(520);
        check("t3_rd_runs", 32'(rd_runs.size()), 32'd1);
        check("t3_bursts", 32'(bursts.size()), 32'd1);
        if (rd_runs.size() == 1 && bursts.size() == 1) begin
            check("t3_grant_delay", 32'(rd_runs[0].start - c_mark), 32'd1);
            check("t3_rd_src", 32'(rd_runs[0].src), 32'd0);
            check("t3_wr_len", 32'(bursts[0].len), FW);
        end
        check("t3_frames0", 32'(frames0), 32'd1);

        // run and src_en[0] drop mid-frame.
        do_reset();
        src_en = 2'b01; src_req = 2'b01; run = 1'b1;
        wait_starts(1, 10, "t4_grant");
        tick(98);
        run = 1'b0; src_en = 2'b00;
        tick(600);
        check("t4_bursts", 32'(bursts.size()), 32'd1);
        if (bursts.size() == 1) check("t4_wr_len", 32'(bursts[0].len), FW);
        check("t4_frames0", 32'(frames0), 32'd1);
        check("t4_starts", 32'(rd_starts), 32'd1);
        src_en = 2'b01;
        tick(50);
        check("t4_no_grant_run0", 32'(rd_starts), 32'd1);

        // Reset in the middle of the third frame.
        do_reset();
        src_en = 2'b11; src_req = 2'b11; run = 1'b1;
        wait_starts(3, 3 * 520 + 50, "t5_three_grants");
        tick(198);
        check("t5_pre_frames0", 32'(frames0), 32'd1);
        check("t5_pre_frames1", 32'(frames1), 32'd1);
        check("t5_pre_busy", 32'(busy), 32'd1);
        nRST = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_rst_src_rd", 32'(src_rd), 32'd0);
        check("t5_rst_fifo_wr", 32'(fifo_wr), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_frames0", 32'(frames0), 32'd0);
        check("t5_rst_frames1", 32'(frames1), 32'd0);
        tick(3);
        bursts.delete();
        rd_runs.delete();
        sb.delete();
        rd_starts = 0;
        nRST = 1'b1;
        wait_starts(1, 10, "t5_grant_after_rst");
        src_req = 2'b00;
        tick(530);
        check("t5_rd_runs", 32'(rd_runs.size()), 32'd1);
        if (rd_runs.size() == 1) check("t5_first_src", 32'(rd_runs[0].src), 32'd0);
        check("t5_bursts", 32'(bursts.size()), 32'd1);
        if (bursts.size() == 1) check("t5_wr_len", 32'(bursts[0].len), FW);

        // Frame counter wrap with a 4-bit counter.
        do_reset();
        src_en = 2'b01; src_req = 2'b01; run = 1'b1;
        wait_starts(17, 17 * 520 + 100, "t6_seventeen_grants");
        src_req = 2'b00;
        tick(530);
        check("t6_bursts", 32'(bursts.size()), 32'd17);
        check("t6_frames0", 32'(frames0), 32'd1);
        check("t6_frames1", 32'(frames1), 32'd0);
        check("t6_sb_empty", 32'(sb.size()), 32'd0);

        check("src_rd_legal", 32'(rd_bad), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
